arbitro_bus_memoria: RTL and testbench

Two-requester memory bus arbiter and access sequencer for the single-port program/data memory of the CISC datapath. It shares the memory between the control unit (instruction fetch, load, store) and the DMA/I-O port, grants one requester at a time, and drives the memory strobes for a fixed number of wait states. It returns a one-cycle completion pulse and registered read data to the granted requester.

---
 rtl/ciscud_pkg.sv | 31 +++
 rtl/arbitro_rr_2.sv | 21 ++
 rtl/arbitro_bus_memoria.sv | 135 +++++++++++++
 tb/tb_arbitro_bus_memoria.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ciscud_pkg.sv
// Shared definitions for the CISC datapath memory arbiter: FSM encoding,
// requester ids, default widths and the wait-counter loader.
package ciscud_pkg;

  localparam int unsigned ANCHO_DIR_DEF     = 16;
  localparam int unsigned ANCHO_DATO_DEF    = 16;
  localparam int unsigned CICLOS_ESPERA_DEF = 2;

  // Wide enough for the legal wait-state range 0..15.
  localparam int unsigned ANCHO_CUENTA = 4;

  localparam logic [1:0] LIBRE  = 2'd0;
  localparam logic [1:0] ACCESO = 2'd1;
  localparam logic [1:0] FIN    = 2'd2;

  typedef enum logic [1:0] {
    StLibre  = LIBRE,
    StAcceso = ACCESO,
    StFin    = FIN
  } estado_e;

  typedef logic id_req_t;

  localparam id_req_t ID_CPU = 1'b0;
  localparam id_req_t ID_DMA = 1'b1;

  function automatic logic [ANCHO_CUENTA-1:0] carga_espera(input int unsigned ciclos);
    return ANCHO_CUENTA'(ciclos);
  endfunction

endpackage

// File: rtl/arbitro_rr_2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to the requester that was not granted last.
module arbitro_rr_2
  import ciscud_pkg::*;
(
  input  logic    req_a_i,
  input  logic    req_b_i,
  input  logic    ultimo_b_i,
  output id_req_t ganador_o,
  output logic    valido_o
);

  always_comb begin
    valido_o  = req_a_i | req_b_i;
    ganador_o = ID_CPU;
    if (req_b_i && (!req_a_i || !ultimo_b_i)) begin
      ganador_o = ID_DMA;
    end
  end

endmodule

// File: rtl/arbitro_bus_memoria.sv
// Arbiter and access sequencer sharing the single-port memory between the
// control unit (A side) and the DMA/I-O port (B side).
module arbitro_bus_memoria
  import ciscud_pkg::*;
#(
  parameter int unsigned ANCHO_DIR     = ANCHO_DIR_DEF,
  parameter int unsigned ANCHO_DATO    = ANCHO_DATO_DEF,
  parameter int unsigned CICLOS_ESPERA = CICLOS_ESPERA_DEF
) (
  input  logic                  Reloj,
  input  logic                  Reiniciar,
  input  logic                  ReqCPU,
  input  logic                  ReqDMA,
  input  logic                  EscCPU,
  input  logic                  EscDMA,
  input  logic [ANCHO_DIR-1:0]  DirCPU,
  input  logic [ANCHO_DIR-1:0]  DirDMA,
  input  logic [ANCHO_DATO-1:0] DatoCPU,
  input  logic [ANCHO_DATO-1:0] DatoDMA,
  output logic                  GntCPU,
  output logic                  GntDMA,
  output logic                  ListoCPU,
  output logic                  ListoDMA,
  output logic [ANCHO_DATO-1:0] DatoLeido,
  output logic [ANCHO_DIR-1:0]  MemDir,
  output logic [ANCHO_DATO-1:0] MemDatoEsc,
  output logic                  MemEsc,
  output logic                  MemLee,
  input  logic [ANCHO_DATO-1:0] MemDatoLeido
);

  estado_e                 estado_q, estado_d;
  id_req_t                 ganador_q, ganador_d;
  logic                    esc_q, esc_d;
  logic [ANCHO_DIR-1:0]    dir_q, dir_d;
  logic [ANCHO_DATO-1:0]   dato_q, dato_d;
  logic [ANCHO_CUENTA-1:0] cuenta_q, cuenta_d;
  logic                    ultimo_dma_q, ultimo_dma_d;
  logic [ANCHO_DATO-1:0]   leido_q, leido_d;

  id_req_t ganador_w;
  logic    valido_w;

  arbitro_rr_2 u_rr (
    .req_a_i    (ReqCPU),
    .req_b_i    (ReqDMA),
    .ultimo_b_i (ultimo_dma_q),
    .ganador_o  (ganador_w),
    .valido_o   (valido_w)
  );

  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      estado_q     <= StLibre;
      ganador_q    <= ID_CPU;
      esc_q        <= 1'b0;
      dir_q        <= '0;
      dato_q       <= '0;
      cuenta_q     <= '0;
      ultimo_dma_q <= 1'b1;
      leido_q      <= '0;
    end else begin
      estado_q     <= estado_d;
      ganador_q    <= ganador_d;
      esc_q        <= esc_d;
      dir_q        <= dir_d;
      dato_q       <= dato_d;
      cuenta_q     <= cuenta_d;
      ultimo_dma_q <= ultimo_dma_d;
      leido_q      <= leido_d;
    end
  end

  always_comb begin
    estado_d     = estado_q;
    ganador_d    = ganador_q;
    esc_d        = esc_q;
    dir_d        = dir_q;
    dato_d       = dato_q;
    cuenta_d     = cuenta_q;
    ultimo_dma_d = ultimo_dma_q;
    leido_d      = leido_q;

    unique case (estado_q)
      StLibre: begin
        if (valido_w) begin
          ganador_d = ganador_w;
          if (ganador_w == ID_DMA) begin
            esc_d  = EscDMA;
            dir_d  = DirDMA;
            dato_d = DatoDMA;
          end else begin
            esc_d  = EscCPU;
            dir_d  = DirCPU;
            dato_d = DatoCPU;
          end
          cuenta_d = carga_espera(CICLOS_ESPERA);
          estado_d = StAcceso;
        end
      end
      StAcceso: begin
        if (cuenta_q != '0) begin
          cuenta_d = cuenta_q - 1'b1;
        end else begin
          // Memory data is only guaranteed valid in the last strobe cycle.
          if (!esc_q) begin
            leido_d = MemDatoLeido;
          end
          ultimo_dma_d = (ganador_q == ID_DMA);
          estado_d     = StFin;
        end
      end
      StFin: begin
        estado_d = StLibre;
      end
      default: begin
        estado_d = StLibre;
      end
    endcase
  end

  // Outputs decode the state register and latches only.
  always_comb begin
    GntCPU     = (estado_q != StLibre) && (ganador_q == ID_CPU);
    GntDMA     = (estado_q != StLibre) && (ganador_q == ID_DMA);
    ListoCPU   = (estado_q == StFin) && (ganador_q == ID_CPU);
    ListoDMA   = (estado_q == StFin) && (ganador_q == ID_DMA);
    MemEsc     = (estado_q == StAcceso) && esc_q;
    MemLee     = (estado_q == StAcceso) && !esc_q;
    MemDir     = dir_q;
    MemDatoEsc = dato_q;
    DatoLeido  = leido_q;
  end

endmodule

// File: tb/tb_arbitro_bus_memoria.sv
// Self-checking bench: table of single accesses plus hand sequences, checked
// through an expected-access queue popped on every Listo pulse.
module tb_arbitro_bus_memoria;

  localparam int CE = 2;

  typedef struct {
    logic        dma;
    logic        esc;
    logic [15:0] dir;
    logic [15:0] dato;
    logic [15:0] leido;
  } vec_t;

  logic        clk = 1'b0;
  logic        Reiniciar = 1'b1;
  logic        ReqCPU = 1'b0, ReqDMA = 1'b0, EscCPU = 1'b0, EscDMA = 1'b0;
  logic [15:0] DirCPU = 16'h7777, DirDMA = 16'h6666;
  logic [15:0] DatoCPU = 16'h1111, DatoDMA = 16'h2222;
  logic        GntCPU, GntDMA, ListoCPU, ListoDMA, MemEsc, MemLee;
  logic [15:0] DatoLeido, MemDir, MemDatoEsc, MemDatoLeido;

  logic        r1_req = 1'b0;
  logic [15:0] r1_dir = 16'h0010;
  logic        Gnt1CPU, Gnt1DMA, Listo1CPU, Listo1DMA, MemEsc1, MemLee1;
  logic [15:0] DatoLeido1, MemDir1, MemDatoEsc1, MemDatoLeido1;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t sb[$];

  always #5 clk = ~clk;

  arbitro_bus_memoria #(.ANCHO_DIR(16), .ANCHO_DATO(16), .CICLOS_ESPERA(CE)) dut (
    .Reloj(clk), .Reiniciar(Reiniciar),
    .ReqCPU(ReqCPU), .ReqDMA(ReqDMA), .EscCPU(EscCPU), .EscDMA(EscDMA),
    .DirCPU(DirCPU), .DirDMA(DirDMA), .DatoCPU(DatoCPU), .DatoDMA(DatoDMA),
    .GntCPU(GntCPU), .GntDMA(GntDMA), .ListoCPU(ListoCPU), .ListoDMA(ListoDMA),
    .DatoLeido(DatoLeido), .MemDir(MemDir), .MemDatoEsc(MemDatoEsc),
    .MemEsc(MemEsc), .MemLee(MemLee), .MemDatoLeido(MemDatoLeido)
  );

  arbitro_bus_memoria #(.ANCHO_DIR(16), .ANCHO_DATO(16), .CICLOS_ESPERA(0)) dut0 (
    .Reloj(clk), .Reiniciar(Reiniciar),
    .ReqCPU(r1_req), .ReqDMA(1'b0), .EscCPU(1'b0), .EscDMA(1'b0),
    .DirCPU(r1_dir), .DirDMA(16'h0000), .DatoCPU(16'h0000), .DatoDMA(16'h0000),
    .GntCPU(Gnt1CPU), .GntDMA(Gnt1DMA), .ListoCPU(Listo1CPU), .ListoDMA(Listo1DMA),
    .DatoLeido(DatoLeido1), .MemDir(MemDir1), .MemDatoEsc(MemDatoEsc1),
    .MemEsc(MemEsc1), .MemLee(MemLee1), .MemDatoLeido(MemDatoLeido1)
  );

  // Memory model: unwritten words read a fixed pattern, 0x0010 holds 0xBEEF.
  function automatic logic [15:0] mem_def(input logic [7:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {8'hC0, a};
  endfunction

  logic        mem_clr = 1'b1;
  logic [15:0] mem [256];
  logic [255:0] escrito;

  always @(posedge clk) begin
    if (mem_clr) begin
      escrito <= '0;
    end else if (MemEsc) begin
      mem[MemDir[7:0]]     <= MemDatoEsc;
      escrito[MemDir[7:0]] <= 1'b1;
    end
  end

  assign MemDatoLeido  = escrito[MemDir[7:0]] ? mem[MemDir[7:0]] : mem_def(MemDir[7:0]);
  assign MemDatoLeido1 = mem_def(MemDir1[7:0]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Counts falling edges up to and including the one showing a Listo pulse.
  task automatic wait_listo(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ListoCPU || ListoDMA) && n < limit);
    check("listo_arrives", 32'(ListoCPU || ListoDMA), 32'd1);
  endtask

  task automatic drive(input vec_t v);
    if (v.dma) begin
      ReqDMA = 1'b1; EscDMA = v.esc; DirDMA = v.dir; DatoDMA = v.dato;
    end else begin
      ReqCPU = 1'b1; EscCPU = v.esc; DirCPU = v.dir; DatoCPU = v.dato;
    end
  endtask

  task automatic run_acc(input vec_t v);
    int n;
    @(posedge clk); #1;
    drive(v);
    sb.push_back(v);
    @(posedge clk); #1;
    ReqCPU = 1'b0;
    ReqDMA = 1'b0;
    wait_listo(20, n);
    check("latency", 32'(n), 32'(CE + 2));
  endtask

  // Monitor: tracks the strobe window of each access, checks it at Listo.
  int          cnt = 0;
  logic        prev_strobe = 1'b0, strobe;
  logic [15:0] f_dir, f_dato;
  logic        f_esc, f_gnt_dma, gnt_ok, changed;
  vec_t        e;

  initial forever begin
    @(negedge clk);
    if (Reiniciar) begin
      cnt = 0;
      prev_strobe = 1'b0;
    end else begin
      strobe = MemEsc | MemLee;
      check("exclusion", 32'({MemEsc & MemLee, GntCPU & GntDMA, ListoCPU & ListoDMA}), 32'd0);
      if (strobe) begin
        if (cnt == 0) begin
          f_dir = MemDir; f_dato = MemDatoEsc; f_esc = MemEsc;
          f_gnt_dma = GntDMA; gnt_ok = GntCPU | GntDMA; changed = 1'b0;
        end else begin
          if (MemDir != f_dir || MemDatoEsc != f_dato || MemEsc != f_esc) changed = 1'b1;
          gnt_ok = gnt_ok & (GntCPU | GntDMA);
        end
        cnt++;
      end
      if (ListoCPU || ListoDMA) begin
        if (sb.size() == 0) begin
          check("unexpected_listo", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("listo_id", 32'(ListoDMA), 32'(e.dma));
          check("gnt_at_listo", 32'({GntDMA, GntCPU}), e.dma ? 32'd2 : 32'd1);
          check("strobe_len", 32'(cnt), 32'(CE + 1));
          check("strobe_then_listo", 32'({prev_strobe, strobe}), 32'b10);
          check("mem_esc", 32'(f_esc), 32'(e.esc));
          check("mem_dir", 32'(f_dir), 32'(e.dir));
          if (e.esc) check("mem_dato_esc", 32'(f_dato), 32'(e.dato));
          check("latch_stable", 32'(changed), 32'd0);
          check("gnt_in_access", 32'({f_gnt_dma, gnt_ok}), 32'({e.dma, 1'b1}));
          check("dato_leido", 32'(DatoLeido), 32'(e.leido));
        end
        cnt = 0;
      end
      prev_strobe = strobe;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tabla[6];
    vec_t v;
    int   n, s;
    logic got, listo_seen;

    tabla[0] = '{dma: 1'b0, esc: 1'b0, dir: 16'h0010, dato: 16'h0000, leido: 16'hBEEF};
    tabla[1] = '{dma: 1'b1, esc: 1'b1, dir: 16'h00A0, dato: 16'h1234, leido: 16'hBEEF};
    tabla[2] = '{dma: 1'b1, esc: 1'b0, dir: 16'h00A0, dato: 16'h0000, leido: 16'h1234};
    tabla[3] = '{dma: 1'b0, esc: 1'b1, dir: 16'h0040, dato: 16'h0F0F, leido: 16'h1234};
    tabla[4] = '{dma: 1'b0, esc: 1'b0, dir: 16'h0040, dato: 16'h9999, leido: 16'h0F0F};
    tabla[5] = '{dma: 1'b1, esc: 1'b0, dir: 16'h0011, dato: 16'h0000, leido: 16'hC011};

    repeat (2) @(posedge clk);
    #1;
    Reiniciar = 1'b0;
    mem_clr   = 1'b0;
    @(negedge clk);
    check("reset_ctl", 32'({GntCPU, GntDMA, ListoCPU, ListoDMA, MemEsc, MemLee}), 32'd0);
    check("reset_leido", 32'(DatoLeido), 32'd0);
    check("reset_memdir", 32'({MemDir, MemDatoEsc}), 32'd0);

    // Zero-wait build: one strobe cycle, Listo two cycles after sampling.
    @(posedge clk); #1;
    r1_req = 1'b1;
    @(posedge clk); #1;
    r1_req = 1'b0;
    n = 0; s = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (MemLee1) s++;
      if (Listo1CPU) got = 1'b1;
    end
    check("ce0_listo_seen", 32'(got), 32'd1);
    check("ce0_latency", 32'(n), 32'd2);
    check("ce0_strobe_len", 32'(s), 32'd1);
    check("ce0_leido", 32'(DatoLeido1), 32'hBEEF);

    for (int i = 0; i < 6; i++) run_acc(tabla[i]);

    // Both requesting continuously: strict alternation, one Listo per 5 cycles.
    @(posedge clk); #1;
    EscCPU = 1'b0; DirCPU = 16'h0020;
    EscDMA = 1'b1; DirDMA = 16'h0020; DatoDMA = 16'h5555;
    ReqCPU = 1'b1; ReqDMA = 1'b1;
    v = '{dma: 1'b0, esc: 1'b0, dir: 16'h0020, dato: 16'h0000, leido: 16'hC020};
    sb.push_back(v);
    v = '{dma: 1'b1, esc: 1'b1, dir: 16'h0020, dato: 16'h5555, leido: 16'hC020};
    sb.push_back(v);
    v = '{dma: 1'b0, esc: 1'b0, dir: 16'h0020, dato: 16'h0000, leido: 16'h5555};
    sb.push_back(v);
    v = '{dma: 1'b1, esc: 1'b1, dir: 16'h0020, dato: 16'h5555, leido: 16'h5555};
    sb.push_back(v);
    for (int k = 0; k < 4; k++) begin
      wait_listo(20, n);
      check("rr_spacing", 32'(n), 32'(CE + 3));
    end
    @(posedge clk); #1;
    ReqCPU = 1'b0; ReqDMA = 1'b0;

    // Inputs change and request drops mid-access: latched values are used.
    @(posedge clk); #1;
    v = '{dma: 1'b0, esc: 1'b1, dir: 16'h0030, dato: 16'hAAAA, leido: 16'h5555};
    drive(v);
    sb.push_back(v);
    @(posedge clk); #1;
    ReqCPU = 1'b0;
    @(posedge clk); #1;
    DirCPU = 16'h0031; DatoCPU = 16'hFFFF; EscCPU = 1'b0;
    wait_listo(20, n);
    check("mid_change_latency", 32'(n), 32'(CE + 1));
    v = '{dma: 1'b0, esc: 1'b0, dir: 16'h0031, dato: 16'h0000, leido: 16'hC031};
    run_acc(v);
    v = '{dma: 1'b0, esc: 1'b0, dir: 16'h0030, dato: 16'h0000, leido: 16'hAAAA};
    run_acc(v);

    // Reset in the second strobe cycle aborts the access with no Listo.
    @(posedge clk); #1;
    ReqCPU = 1'b1; EscCPU = 1'b0; DirCPU = 16'h0010;
    @(posedge clk); #1;
    ReqCPU = 1'b0;
    @(posedge clk); #1;
    Reiniciar = 1'b1;
    @(posedge clk); #1;
    Reiniciar = 1'b0;
    @(negedge clk);
    check("abort_ctl", 32'({GntCPU, GntDMA, ListoCPU, ListoDMA, MemEsc, MemLee}), 32'd0);
    check("abort_leido", 32'(DatoLeido), 32'd0);
    check("abort_memdir", 32'(MemDir), 32'd0);
    listo_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      listo_seen = listo_seen | ListoCPU | ListoDMA | GntCPU | GntDMA;
    end
    check("abort_quiet", 32'(listo_seen), 32'd0);

    // First tie after reset goes to the CPU.
    @(posedge clk); #1;
    EscCPU = 1'b0; DirCPU = 16'h0010;
    EscDMA = 1'b0; DirDMA = 16'h0040;
    ReqCPU = 1'b1; ReqDMA = 1'b1;
    v = '{dma: 1'b0, esc: 1'b0, dir: 16'h0010, dato: 16'h0000, leido: 16'hBEEF};
    sb.push_back(v);
    v = '{dma: 1'b1, esc: 1'b0, dir: 16'h0040, dato: 16'h0000, leido: 16'h0F0F};
    sb.push_back(v);
    wait_listo(20, n);
    check("tie_cpu_first", 32'(ListoCPU), 32'd1);
    @(posedge clk); #1;
    ReqCPU = 1'b0;
    wait_listo(20, n);
    check("tie_dma_spacing", 32'(n), 32'(CE + 3));
    @(posedge clk); #1;
    ReqDMA = 1'b0;

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
